// File: rtl/aes_input_masker_if.sv
// Handshake and data bundle between the AES input masker, its upstream source,
// the PRNG and the masked core. The masker sits on the slave modport.
interface aes_input_masker_if #(
   parameter int d = 2
);
   localparam int RND_W = 256 * (d - 1);

   logic               in_valid;
   logic               in_ready;
   logic [127:0]       plaintext;
   logic [127:0]       key;
   logic [RND_W-1:0]   rnd_in;
   logic               rnd_valid;
   logic               rnd_ready;
   logic               out_valid;
   logic               out_ready;
   logic [128*d-1:0]   sh_plaintext;
   logic [128*d-1:0]   sh_key;
   logic               busy;

   modport slave (
      input  in_valid, plaintext, key, rnd_in, rnd_valid, out_ready,
      output in_ready, rnd_ready, out_valid, sh_plaintext, sh_key, busy
   );

   modport master (
      output in_valid, plaintext, key, rnd_in, rnd_valid, out_ready,
      input  in_ready, rnd_ready, out_valid, sh_plaintext, sh_key, busy
   );
endinterface

// File: rtl/aes_input_masker.sv
// Splits one plaintext/key pair into a d-share bit-interleaved Boolean sharing.
// Optional AES_MASKER_ZEROIZE_EN clears the share registers on handover.
module aes_input_masker #(
   parameter int d = 2
) (
   input  logic               clk,
   input  logic               nrst,
   aes_input_masker_if.slave  bus,
   output logic [1:0]         dbg_state_o
);
   // All three handshakes are valid/ready: a transfer happens on a rising edge
   // where both are high; valid never depends combinationally on ready.

   if (d < 2) begin : g_bad_d
      $error("aes_input_masker: d must be at least 2");
   end

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      WAIT_RND = 2'd1,
      OUT      = 2'd2
   } state_e;

   state_e             state_q, state_d;
   logic [127:0]       pt_raw_q, pt_raw_d;
   logic [127:0]       key_raw_q, key_raw_d;
   logic [128*d-1:0]   sh_pt_q, sh_pt_d;
   logic [128*d-1:0]   sh_key_q, sh_key_d;
   logic [128*d-1:0]   sh_pt_cap, sh_key_cap;

   // Share 0 is built only from the raw registers and the PRNG word, so the
   // unmasked inputs never feed the share outputs directly.
   for (genvar j = 0; j < 128; j++) begin : g_bit
      logic [d-1:1] pt_r, key_r;
      for (genvar i = 1; i < d; i++) begin : g_share
         assign pt_r[i]  = bus.rnd_in[128*(i-1) + j];
         assign key_r[i] = bus.rnd_in[128*(d-1) + 128*(i-1) + j];
      end
      assign sh_pt_cap[d*j +: d]  = {pt_r, pt_raw_q[j] ^ (^pt_r)};
      assign sh_key_cap[d*j +: d] = {key_r, key_raw_q[j] ^ (^key_r)};
   end

   always_comb begin
      state_d       = state_q;
      pt_raw_d      = pt_raw_q;
      key_raw_d     = key_raw_q;
      sh_pt_d       = sh_pt_q;
      sh_key_d      = sh_key_q;
      bus.in_ready  = 1'b0;
      bus.rnd_ready = 1'b0;
      bus.out_valid = 1'b0;
      bus.busy      = 1'b1;
      case (state_q)
         IDLE: begin
            bus.in_ready = 1'b1;
            bus.busy     = 1'b0;
            if (bus.in_valid) begin
               pt_raw_d  = bus.plaintext;
               key_raw_d = bus.key;
               state_d   = WAIT_RND;
            end
         end
         WAIT_RND: begin
            bus.rnd_ready = 1'b1;
            if (bus.rnd_valid) begin
               sh_pt_d   = sh_pt_cap;
               sh_key_d  = sh_key_cap;
               pt_raw_d  = '0;
               key_raw_d = '0;
               state_d   = OUT;
            end
         end
         OUT: begin
            bus.out_valid = 1'b1;
            if (bus.out_ready) begin
               state_d = IDLE;
`ifdef AES_MASKER_ZEROIZE_EN
               sh_pt_d  = '0;
               sh_key_d = '0;
`endif
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state_q   <= IDLE;
         pt_raw_q  <= '0;
         key_raw_q <= '0;
         sh_pt_q   <= '0;
         sh_key_q  <= '0;
      end else begin
         state_q   <= state_d;
         pt_raw_q  <= pt_raw_d;
         key_raw_q <= key_raw_d;
         sh_pt_q   <= sh_pt_d;
         sh_key_q  <= sh_key_d;
      end
   end

   assign bus.sh_plaintext = sh_pt_q;
   assign bus.sh_key       = sh_key_q;
   assign dbg_state_o      = state_q;
endmodule

// File: tb/tb_aes_input_masker.sv
// Directed bench for aes_input_masker with a d=2 and a d=3 instance.
module tb_aes_input_masker;
   logic clk = 1'b0;
   logic nrst;
   always #5 clk = ~clk;

   aes_input_masker_if #(.d(2)) b2 ();
   aes_input_masker_if #(.d(3)) b3 ();
   logic [1:0] st2, st3;

   aes_input_masker #(.d(2)) dut2 (.clk(clk), .nrst(nrst), .bus(b2), .dbg_state_o(st2));
   aes_input_masker #(.d(3)) dut3 (.clk(clk), .nrst(nrst), .bus(b3), .dbg_state_o(st3));

   int checks = 0;
   int errors = 0;

   localparam logic [127:0] P   = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] K   = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] P4  = 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
   localparam logic [127:0] K4  = 128'hffeeddccbbaa99887766554433221100;
   localparam logic [127:0] RA  = 128'h55aa33cc0ff0f00f1234567890abcdef;
   localparam logic [127:0] RB  = 128'hfedcba0987654321a5a5a5a55a5a5a5a;
   localparam logic [127:0] P3  = 128'h3243f6a8885a308d313198a2e0370734;
   localparam logic [127:0] K3  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] R1  = 128'h6b1f0a93c4e27d5809ab3c7e51f2d84a;
   localparam logic [127:0] R2  = 128'h9e0c47b2f15a3d8867e4c1b09a2f5d73;
   localparam logic [127:0] RK1 = 128'hc3a57e091b6d4f28e7b2093c5a8d1f64;
   localparam logic [127:0] RK2 = 128'h1f8e2b7c4d09a6e35b7f1c8e02d4a96b;

   function automatic logic [255:0] ilv2(input logic [127:0] s0, input logic [127:0] s1);
      logic [255:0] r;
      r = '0;
      for (int j = 0; j < 128; j++) begin
         r[2*j]   = s0[j];
         r[2*j+1] = s1[j];
      end
      return r;
   endfunction

   function automatic logic [383:0] ilv3(input logic [127:0] s0, input logic [127:0] s1,
                                         input logic [127:0] s2);
      logic [383:0] r;
      r = '0;
      for (int j = 0; j < 128; j++) begin
         r[3*j]   = s0[j];
         r[3*j+1] = s1[j];
         r[3*j+2] = s2[j];
      end
      return r;
   endfunction

   function automatic logic [127:0] fold2(input logic [255:0] v);
      logic [127:0] r;
      for (int j = 0; j < 128; j++) r[j] = v[2*j] ^ v[2*j+1];
      return r;
   endfunction

   function automatic logic [127:0] fold3(input logic [383:0] v);
      logic [127:0] r;
      for (int j = 0; j < 128; j++) r[j] = v[3*j] ^ v[3*j+1] ^ v[3*j+2];
      return r;
   endfunction

   task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_idle2(input string tag);
      chk({tag, " st"}, 512'(st2), 512'(0));
      chk({tag, " in_ready"}, 512'(b2.in_ready), 512'(1));
      chk({tag, " rnd_ready"}, 512'(b2.rnd_ready), 512'(0));
      chk({tag, " out_valid"}, 512'(b2.out_valid), 512'(0));
      chk({tag, " busy"}, 512'(b2.busy), 512'(0));
   endtask

   logic [255:0] exp_pt, exp_key;
   logic [383:0] exp3_pt, exp3_key;

   initial begin
      nrst = 1'b0;
      b2.in_valid = 0; b2.plaintext = '0; b2.key = '0; b2.rnd_in = '0;
      b2.rnd_valid = 0; b2.out_ready = 0;
      b3.in_valid = 0; b3.plaintext = '0; b3.key = '0; b3.rnd_in = '0;
      b3.rnd_valid = 0; b3.out_ready = 0;
      repeat (2) step();

      // Reset state
      chk_idle2("rst2");
      chk("rst2 sh_pt", 512'(b2.sh_plaintext), 512'(0));
      chk("rst2 sh_key", 512'(b2.sh_key), 512'(0));
      chk("rst3 in_ready", 512'(b3.in_ready), 512'(1));
      chk("rst3 busy", 512'(b3.busy), 512'(0));
      chk("rst3 sh_pt", 512'(b3.sh_plaintext), 512'(0));
      nrst = 1'b1;
      step();

      // d=2, all-ones randomness held high
      b2.plaintext = P; b2.key = K; b2.rnd_in = '1; b2.rnd_valid = 1; b2.in_valid = 1;
      #1;
      chk("s2 rnd_ready in IDLE", 512'(b2.rnd_ready), 512'(0));
      step();
      b2.in_valid = 0;
      chk("s2 st wait", 512'(st2), 512'(1));
      chk("s2 out_valid early", 512'(b2.out_valid), 512'(0));
      chk("s2 busy", 512'(b2.busy), 512'(1));
      chk("s2 in_ready", 512'(b2.in_ready), 512'(0));
      chk("s2 pt_raw", 512'(dut2.pt_raw_q), 512'(P));
      step();
      exp_pt  = ilv2(~P, '1);
      exp_key = ilv2(~K, '1);
      chk("s2 out_valid", 512'(b2.out_valid), 512'(1));
      chk("s2 rnd_ready in OUT", 512'(b2.rnd_ready), 512'(0));
      chk("s2 sh_pt", 512'(b2.sh_plaintext), 512'(exp_pt));
      chk("s2 sh_key", 512'(b2.sh_key), 512'(exp_key));
      chk("s2 recomb pt", 512'(fold2(b2.sh_plaintext)), 512'(P));
      chk("s2 recomb key", 512'(fold2(b2.sh_key)), 512'(K));
      chk("s2 raw zero", 512'({dut2.pt_raw_q, dut2.key_raw_q}), 512'(0));
      b2.out_ready = 1;
      step();
      b2.out_ready = 0; b2.rnd_valid = 0;
      chk_idle2("s2 handover");
`ifdef AES_MASKER_ZEROIZE_EN
      chk("s6 zeroize pt", 512'(b2.sh_plaintext), 512'(0));
      chk("s6 zeroize key", 512'(b2.sh_key), 512'(0));
`else
      chk("s6 keep pt", 512'(b2.sh_plaintext), 512'(exp_pt));
      chk("s6 keep key", 512'(b2.sh_key), 512'(exp_key));
`endif

      // d=2, core stalls for 10 cycles in OUT
      b2.plaintext = P4; b2.key = K4; b2.rnd_in = {RB, RA}; b2.rnd_valid = 1; b2.in_valid = 1;
      step();
      b2.in_valid = 0;
      step();
      b2.rnd_valid = 0;
      exp_pt  = ilv2(P4 ^ RA, RA);
      exp_key = ilv2(K4 ^ RB, RB);
      for (int k = 0; k < 10; k++) begin
         b2.in_valid  = k[0];
         b2.plaintext = 128'(k) * 128'h1111;
         b2.rnd_in    = ~b2.rnd_in;
         b2.rnd_valid = k[1];
         step();
         chk($sformatf("s4 st c%0d", k), 512'(st2), 512'(2));
         chk($sformatf("s4 in_ready c%0d", k), 512'(b2.in_ready), 512'(0));
         chk($sformatf("s4 sh_pt c%0d", k), 512'(b2.sh_plaintext), 512'(exp_pt));
         chk($sformatf("s4 sh_key c%0d", k), 512'(b2.sh_key), 512'(exp_key));
      end
      b2.in_valid = 1; b2.rnd_valid = 0; b2.out_ready = 1;
      #1;
      chk("s4 in_ready at out_ready", 512'(b2.in_ready), 512'(0));
      step();
      b2.in_valid = 0; b2.out_ready = 0;
      chk_idle2("s4 back idle");
      step();
      chk("s4 no capture", 512'(st2), 512'(0));

      // d=3, randomness delayed 5 cycles
      b3.plaintext = P3; b3.key = K3; b3.rnd_in = {RK2, RK1, R2, R1}; b3.in_valid = 1;
      step();
      b3.in_valid = 0;
      for (int k = 0; k < 5; k++) begin
         chk($sformatf("s3 rnd_ready c%0d", k), 512'(b3.rnd_ready), 512'(1));
         chk($sformatf("s3 out_valid c%0d", k), 512'(b3.out_valid), 512'(0));
         chk($sformatf("s3 st c%0d", k), 512'(st3), 512'(1));
         step();
      end
      b3.rnd_valid = 1;
      step();
      b3.rnd_valid = 0;
      exp3_pt  = ilv3(P3 ^ R1 ^ R2, R1, R2);
      exp3_key = ilv3(K3 ^ RK1 ^ RK2, RK1, RK2);
      chk("s3 out_valid", 512'(b3.out_valid), 512'(1));
      chk("s3 sh_pt", 512'(b3.sh_plaintext), 512'(exp3_pt));
      chk("s3 sh_key", 512'(b3.sh_key), 512'(exp3_key));
      chk("s3 recomb pt", 512'(fold3(b3.sh_plaintext)), 512'(P3));
      chk("s3 recomb key", 512'(fold3(b3.sh_key)), 512'(K3));
      chk("s3 raw zero", 512'({dut3.pt_raw_q, dut3.key_raw_q}), 512'(0));
      b3.out_ready = 1;
      step();
      b3.out_ready = 0;
      chk("s3 idle", 512'(st3), 512'(0));

      // d=2, reset while waiting for randomness
      b2.plaintext = P; b2.key = K; b2.rnd_valid = 0; b2.in_valid = 1;
      step();
      b2.in_valid = 0;
      chk("s5 st wait", 512'(st2), 512'(1));
      #2 nrst = 1'b0;
      #1;
      chk_idle2("s5 reset");
      chk("s5 raw zero", 512'({dut2.pt_raw_q, dut2.key_raw_q}), 512'(0));
      chk("s5 sh_pt zero", 512'(b2.sh_plaintext), 512'(0));
      chk("s5 sh_key zero", 512'(b2.sh_key), 512'(0));
      nrst = 1'b1;
      step();
      b2.rnd_in = '1; b2.rnd_valid = 1; b2.in_valid = 1;
      step();
      b2.in_valid = 0;
      chk("s5 out_valid early", 512'(b2.out_valid), 512'(0));
      step();
      exp_pt  = ilv2(~P, '1);
      exp_key = ilv2(~K, '1);
      chk("s5 out_valid", 512'(b2.out_valid), 512'(1));
      chk("s5 sh_pt", 512'(b2.sh_plaintext), 512'(exp_pt));
      chk("s5 sh_key", 512'(b2.sh_key), 512'(exp_key));
      b2.out_ready = 1;
      step();
      b2.out_ready = 0; b2.rnd_valid = 0;
      chk_idle2("s5 handover");
`ifdef AES_MASKER_ZEROIZE_EN
      chk("s5 zeroize pt", 512'(b2.sh_plaintext), 512'(0));
`else
      chk("s5 keep pt", 512'(b2.sh_plaintext), 512'(exp_pt));
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/aes_input_masker.md
Name: aes_input_masker

Overview:
- Upstream stage of the masked AES-128 core: takes one unmasked plaintext/key pair and fresh randomness from the PRNG.
- Produces a d-share Boolean sharing of both, in bit-interleaved layout.
- Holds the sharing stable until the core accepts it: out_valid/out_ready connect to the core's valid_in/ready.
- Randomness is pulled over the PRNG's out_valid/out_ready handshake.

Parameters:
- d, 2, number of shares; values below 2 are a configuration error, flagged by a generate-time $error.
- RND_W, 256*(d-1), derived localparam; width of the randomness input.

Ports:
- clk  in  1  system clock
- nrst  in  1  asynchronous active-low reset
- in_valid  in  1  plaintext/key offered
- in_ready  out  1  block can accept plaintext/key
- plaintext  in  128  unmasked plaintext
- key  in  128  unmasked key
- rnd_in  in  RND_W  fresh random bits from PRNG
- rnd_valid  in  1  PRNG output valid
- rnd_ready  out  1  block consumes rnd_in this cycle
- out_valid  out  1  sharing valid toward core
- out_ready  in  1  core accepts sharing
- sh_plaintext  out  128*d  shared plaintext
- sh_key  out  128*d  shared key
- busy  out  1  block holds a transaction (state != IDLE)

Behaviour:
- Clock and reset: one clock, clk; reset nrst is asynchronous, active-low.
- Reset values: all registers 0, state IDLE; outputs in_ready=1, rnd_ready=0, out_valid=0, busy=0, sh_plaintext=0, sh_key=0.
- Reset asserted mid-operation: state returns to IDLE and every data register clears, including raw and share registers. The pending transaction is dropped and no partial output appears.
- FSM states: IDLE, WAIT_RND, OUT.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready: register plaintext and key into raw registers, go to WAIT_RND.
- WAIT_RND:
  - rnd_ready=1 combinationally; in_ready=0.
  - On rnd_valid: register the shares, zero the raw registers in the same edge, go to OUT.
  - If rnd_valid is low, wait indefinitely.
- OUT:
  - out_valid=1; sh_* are stable.
  - On out_ready: go to IDLE.
  - in_ready=0, so no new input is taken in the out_ready cycle. IDLE is entered on the next edge.
- Share layout, bit j in 0..127, share i in 0..d-1, index d*j+i:
  - For i>=1: sh_plaintext[d*j+i] = rnd_in[128*(i-1)+j].
  - For i>=1: sh_key[d*j+i] = rnd_in[128*(d-1)+128*(i-1)+j].
  - For i=0: sh_plaintext[d*j] = plaintext_raw[j] XOR (XOR over i>=1 of sh_plaintext[d*j+i]). sh_key[d*j] is formed the same way from key_raw.
- Latency: input accepted at edge N; rnd_valid already high gives shares registered at edge N+1; out_valid high from cycle N+1. Minimum 2 edges from input accept to the core seeing valid.
- Throughput: at most one block per 3 cycles. This is acceptable against the multi-cycle core.
- rnd_valid while not in WAIT_RND: ignored; no random word is consumed (rnd_ready=0).
- in_valid outside IDLE: ignored; the upstream source holds it.
- Unshared plaintext or key never reaches sh_* outputs, even transiently. Share 0 is combined from registered values only.
- busy=1 in WAIT_RND and OUT.

Optional Feature:
- Macro: AES_MASKER_ZEROIZE_EN.
- Defined:
  - On the out_ready handshake in OUT, sh_plaintext and sh_key registers clear to 0 in the same edge that enters IDLE.
  - Any out_valid=0 cycle shows all-zero shares.
- Undefined: share registers keep their last value after handover until the next randomness capture; only the raw registers are zeroed.

Test Plan:
1. Reset then idle -> in_ready=1, rnd_ready=0, out_valid=0, busy=0, sh_*=0.
2. d=2: plaintext=0x00112233445566778899aabbccddeeff, key=0x000102030405060708090a0b0c0d0e0f, rnd_in all-ones, rnd_valid held high.
   - Required: out_valid at 2nd edge after accept.
   - Odd bits (share 1) are all 1; even bits (share 0) are ~plaintext / ~key.
   - Per-bit XOR of the shares equals plaintext/key.
3. d=3, random rnd_in, rnd_valid delayed 5 cycles:
   - Required: rnd_ready high for those 5 cycles and out_valid low throughout.
   - Shares recombine correctly.
   - Raw registers read 0 in OUT.
4. out_ready held low for 10 cycles in OUT -> sh_* stable, in_ready=0, in_valid pulses ignored; out_ready=1 -> IDLE next edge.
5. nrst asserted while in WAIT_RND -> immediate IDLE, all registers 0; the following transaction behaves as in scenario 2.
6. With AES_MASKER_ZEROIZE_EN defined, complete scenario 2 -> sh_* read 0 the cycle after out_ready. Without the macro, sh_* keep the last sharing.
